logic_unit_seq: RTL and testbench

LOGIC_UNIT_SEQ -- requirements
Module: logic_unit_seq

---
 rtl/logic_unit_seq_if.sv | 26 ++
 rtl/logic_unit_seq.sv | 124 ++++++++++++
 tb/tb_logic_unit_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_seq_if.sv
// Request/result handshake bundle for logic_unit_seq.
// master drives requests and accepts results; slave is the unit.
interface logic_unit_seq_if #(
  parameter int N   = 8,
  parameter int OPW = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic [OPW-1:0] opcode;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   result;
  logic           zero;

  modport master (
    output in_valid, A, B, opcode, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, A, B, opcode, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/logic_unit_seq.sv
// Sequential logic unit: bitwise/compare ops in one step,
// popcount and rotate-left iterated one bit per cycle.
module logic_unit_seq #(
  parameter int N   = 8,
  parameter int OPW = 4
) (
  input logic            clk,
  input logic            rst_n,
  logic_unit_seq_if.slave bus
);
  localparam int LW = $clog2(N);
  localparam int CW = LW + 1;
  localparam logic [OPW-1:0] OP_POP = OPW'(8);
  localparam logic [OPW-1:0] OP_ROT = OPW'(9);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t         state;
  logic [N-1:0]   a_q;
  logic [OPW-1:0] op_q;
  logic [N-1:0]   acc;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   res_q;
  logic           vld_q;
  logic           zero_q;

  logic [N-1:0]   alu;
  logic [N-1:0]   rot1;
  logic [N-1:0]   pop_fin;
  logic [N-1:0]   bnxt;
  logic [CW-1:0]  k;
  logic           is_pop;
  logic           is_rot;

  assign k      = CW'(bus.B[LW-1:0]);
  assign is_pop = (bus.opcode == OP_POP);
  assign is_rot = (bus.opcode == OP_ROT);

  always_comb begin
    alu = bus.A;
    case (bus.opcode)
      OPW'(0): alu = bus.A & bus.B;
      OPW'(1): alu = bus.A | bus.B;
      OPW'(2): alu = bus.A ^ bus.B;
      OPW'(3): alu = ~(bus.A | bus.B);
      OPW'(4): alu = ~(bus.A & bus.B);
      OPW'(5): alu = ~(bus.A ^ bus.B);
      OPW'(6): alu = N'(bus.A > bus.B);
      OPW'(7): alu = N'(bus.A == bus.B);
      default: alu = bus.A;
    endcase
  end

  // a_q is consumed from the bottom for popcount,
  // and rotated in place for rotate-left.
  assign rot1    = {a_q[N-2:0], a_q[N-1]};
  assign pop_fin = acc + N'(a_q[0]);
  assign bnxt    = (op_q == OP_POP) ? pop_fin : rot1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      op_q   <= '0;
      acc    <= '0;
      cnt    <= '0;
      res_q  <= '0;
      vld_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q  <= bus.A;
            op_q <= bus.opcode;
            acc  <= '0;
            cnt  <= is_pop ? CW'(N) : k;
            unique case (1'b1)
              is_pop: state <= BUSY;
              (is_rot && k != '0): state <= BUSY;
              default: begin
                res_q  <= alu;
                zero_q <= (alu == '0);
                vld_q  <= 1'b1;
                state  <= DONE;
              end
            endcase
          end
        end
        BUSY: begin
          cnt <= cnt - 1'b1;
          if (op_q == OP_POP) begin
            acc <= pop_fin;
            a_q <= a_q >> 1;
          end else begin
            a_q <= rot1;
          end
          if (cnt == CW'(1)) begin
            res_q  <= bnxt;
            zero_q <= (bnxt == '0);
            vld_q  <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            vld_q <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = rst_n && (state == IDLE);
  assign bus.out_valid = vld_q;
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_logic_unit_seq.sv
// Scoreboard bench for logic_unit_seq: directed cases
// plus random traffic against a behavioural model.
module tb_logic_unit_seq;
  localparam int N   = 8;
  localparam int OPW = 4;

  typedef struct {
    logic [N-1:0] res;
    logic         z;
    int           acc;
    int           lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_err;
  int   rmode;
  exp_t q[$];

  logic_unit_seq_if #(.N(N), .OPW(OPW)) bus ();

  logic_unit_seq #(.N(N), .OPW(OPW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [N-1:0] ref_res(
    input logic [N-1:0] a, input logic [N-1:0] b,
    input logic [OPW-1:0] op
  );
    logic [2*N-1:0] t;
    int kk;
    kk = int'(b) % N;
    case (int'(op))
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return ~(a | b);
      4: return ~(a & b);
      5: return ~(a ^ b);
      6: return (a > b) ? N'(1) : N'(0);
      7: return (a == b) ? N'(1) : N'(0);
      8: return N'($countones(a));
      9: begin
        t = {a, a} << kk;
        return t[2*N-1:N];
      end
      default: return a;
    endcase
  endfunction

  function automatic int ref_lat(
    input logic [N-1:0] b, input logic [OPW-1:0] op
  );
    if (int'(op) == 8) return N + 1;
    if (int'(op) == 9) return (int'(b) % N) + 1;
    return 1;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at cycle %0d",
               nm, act, want, cyc);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input logic [N-1:0] a,
                      input logic [N-1:0] b,
                      input logic [OPW-1:0] op);
    int   w;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.B        = b;
    bus.opcode   = op;
    w = 0;
    while (!bus.in_ready && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.res = ref_res(a, b, op);
    e.z   = (e.res == '0);
    e.acc = cyc;
    e.lat = ref_lat(b, op);
    q.push_back(e);
    bus.in_valid = 1'b0;
    bus.A        = N'($urandom);
    bus.B        = N'($urandom);
    bus.opcode   = OPW'($urandom);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rmode)
        0: bus.out_ready = 1'b0;
        1: bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom);
      endcase
    end
  end

  // Monitor: checks handshake rules and pops the scoreboard.
  initial begin
    bit   seen;
    exp_t e;
    seen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 0;
      end else begin
        if (q.size() != 0)
          chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
        else
          chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        if (bus.out_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_out_valid", 32'd1, 32'd0);
          end else begin
            e = q[0];
            chk("result", 32'(bus.result), 32'(e.res));
            chk("zero", 32'(bus.zero), 32'(e.z));
            if (!seen)
              chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            seen = 1;
            if (bus.out_ready) begin
              void'(q.pop_front());
              seen = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    int w;
    cyc          = 0;
    n_vec        = 0;
    n_err        = 0;
    rmode        = 1;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.A        = '0;
    bus.B        = '0;
    bus.opcode   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

    for (int op = 0; op < 6; op++)
      send(8'hC5, 8'h3A, OPW'(op));
    send(8'h05, 8'h03, 4'd6);
    send(8'h05, 8'h05, 4'd6);
    send(8'h05, 8'h05, 4'd7);
    send(8'hB7, 8'h00, 4'd8);
    send(8'h81, 8'h0B, 4'd9);
    send(8'h81, 8'h08, 4'd9);
    send(8'h81, 8'h07, 4'd9);
    send(8'hFF, 8'h00, 4'd8);
    send(8'h00, 8'h00, 4'd8);
    send(8'h5A, 8'h00, 4'd12);
    drain();

    rmode = 0;
    send(8'hF0, 8'h0F, 4'd0);
    w = 0;
    while (!bus.out_valid && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("hold_valid_seen", 32'(bus.out_valid), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("hold_valid", 32'(bus.out_valid), 32'd1);
    chk("hold_result", 32'(bus.result), 32'h00);
    chk("hold_zero", 32'(bus.zero), 32'd1);
    rmode = 1;
    drain();
    chk("after_hold_in_ready", 32'(bus.in_ready), 32'd1);

    send(8'hB7, 8'h00, 4'd8);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_result", 32'(bus.result), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("midrst_rel_ready", 32'(bus.in_ready), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    send(8'h3C, 8'h00, 4'd8);
    drain();

    rmode = 2;
    for (int i = 0; i < 150; i++) begin
      logic [OPW-1:0] op;
      op = OPW'($urandom);
      if ($urandom_range(0, 3) == 0)
        op = OPW'($urandom_range(8, 9));
      send(N'($urandom), N'($urandom), op);
    end
    drain();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
